// File: rtl/conditional_unit_simd_if.sv
// Bus bundle for the SIMD conditional unit.
// The master side is the pipeline E stage, which drives decoder enables and
// ALU flags. The slave side is the conditional unit, which returns qualified
// enables, the per-lane write mask and its architectural state.
interface conditional_unit_simd_if #(
  parameter int LANES = 4
);
  logic                 StallE;
  logic                 PCSrcE;
  logic                 RegWriteE;
  logic                 MemWriteE;
  logic                 FlagWriteE;
  logic                 BranchE;
  logic [3:0]           CondE;
  logic [4*LANES-1:0]   ALUFlagsE;

  logic                 BranchTakenE;
  logic                 PCSrcECU;
  logic                 RegWriteECU;
  logic                 MemWriteECU;
  logic [LANES-1:0]     LaneMaskECU;
  logic [4*LANES-1:0]   FlagsQ;
  logic                 ShadowE;

  modport master (
    output StallE, PCSrcE, RegWriteE, MemWriteE, FlagWriteE, BranchE,
           CondE, ALUFlagsE,
    input  BranchTakenE, PCSrcECU, RegWriteECU, MemWriteECU, LaneMaskECU,
           FlagsQ, ShadowE
  );

  modport slave (
    input  StallE, PCSrcE, RegWriteE, MemWriteE, FlagWriteE, BranchE,
           CondE, ALUFlagsE,
    output BranchTakenE, PCSrcECU, RegWriteECU, MemWriteECU, LaneMaskECU,
           FlagsQ, ShadowE
  );
endinterface

// File: rtl/conditional_unit_simd.sv
// SIMD conditional execution unit.
// Each lane holds an {N,Z,C,V} flag set. The E-stage condition code is
// evaluated per lane, and the lane results are reduced to a single scalar
// predicate that qualifies the branch and write enables. After a taken branch
// a shadow counter squashes KILL_CYCLES wrong-path instructions.
// Optional feature macro: COND_ANY_EN. When it is defined, CondE[3]=1 selects
// ANY-lane reduction. When it is undefined, ALL-lane reduction is always used.
module conditional_unit_simd #(
  parameter int LANES       = 4,
  parameter int KILL_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  conditional_unit_simd_if.slave bus
);

  localparam logic [2:0] KILL_LOAD = 3'(KILL_CYCLES);

  logic [4*LANES-1:0] flags_q;
  logic [2:0]         counter;
  logic [LANES-1:0]   cond_ex;
  logic               cond_ex_s;
  logic               shadow;
  logic               kill;
  logic               branch_taken;

  // Evaluates one lane's condition from its {N,Z,C,V} flags.
  function automatic logic eval_cond(input logic [3:0] f, input logic [2:0] cc);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      3'b000:  eval_cond = z;
      3'b001:  eval_cond = !z;
      3'b010:  eval_cond = !z && (n == v);
      3'b011:  eval_cond = (n != v);
      3'b100:  eval_cond = (n == v);
      3'b101:  eval_cond = z || (n != v);
      3'b110:  eval_cond = c;
      default: eval_cond = 1'b1;
    endcase
  endfunction

  // Per-lane condition results taken from the architectural flags.
  always_comb begin
    cond_ex = '0;
    for (int k = 0; k < LANES; k++) begin
      cond_ex[k] = eval_cond(flags_q[4*k +: 4], bus.CondE[2:0]);
    end
  end

  // Lane reduction to one scalar predicate; ANY only exists in the macro build.
  always_comb begin
`ifdef COND_ANY_EN
    cond_ex_s = bus.CondE[3] ? (|cond_ex) : (&cond_ex);
`else
    cond_ex_s = &cond_ex;
`endif
  end

  assign shadow       = (counter != 3'd0);
  assign kill         = shadow | rst;
  assign branch_taken = bus.BranchE & cond_ex_s & ~kill;

  // Qualified enables and lane mask, all zero-latency from the current inputs.
  always_comb begin
    bus.BranchTakenE = branch_taken;
    bus.PCSrcECU     = bus.PCSrcE    & cond_ex_s & ~kill;
    bus.RegWriteECU  = bus.RegWriteE & cond_ex_s & ~kill;
    bus.MemWriteECU  = bus.MemWriteE & cond_ex_s & ~kill;
    bus.LaneMaskECU  = (bus.RegWriteE & ~kill) ? cond_ex : '0;
  end

  // Flag register: loads only when the instruction is predicated true and alive.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (!bus.StallE && bus.FlagWriteE && cond_ex_s && !kill) begin
      flags_q <= bus.ALUFlagsE;
    end
  end

  // Shadow counter: a taken branch reloads it, otherwise it drains on unstalled edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= 3'd0;
    end else if (!bus.StallE) begin
      if (branch_taken) begin
        counter <= KILL_LOAD;
      end else if (counter != 3'd0) begin
        counter <= counter - 3'd1;
      end
    end
  end

  assign bus.FlagsQ  = flags_q;
  assign bus.ShadowE = shadow;

endmodule

// File: doc/conditional_unit_simd.md
CONDITIONAL_UNIT_SIMD -- requirements
Module: conditional_unit_simd

Interface
REQ-001 Parameter LANES, default 4, meaning number of SIMD lanes, each carrying one 4-bit flag set {N,Z,C,V} at bits [3],[2],[1],[0]; lane k occupies bits [4k+3:4k].
REQ-002 Parameter KILL_CYCLES, default 2, meaning number of wrong-path E-stage instructions squashed after a taken branch (range 0..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 StallE  input  1  E stage held; state frozen.
REQ-006 PCSrcE, RegWriteE, MemWriteE, FlagWriteE  input  1 each  decoder enables for the E-stage instruction.
REQ-007 BranchE  input  1  E-stage instruction is a branch.
REQ-008 CondE  input  4  [2:0] condition code; [3] lane reduction, 0=ALL, 1=ANY.
REQ-009 ALUFlagsE  input  4*LANES  per-lane flags produced by the E-stage ALU.
REQ-010 BranchTakenE, PCSrcECU, RegWriteECU, MemWriteECU  output  1 each  qualified enables.
REQ-011 LaneMaskECU  output  LANES  per-lane write predicate.
REQ-012 FlagsQ  output  4*LANES  architectural flag register.
REQ-013 ShadowE  output  1  high while the wrong-path squash is active.

Function
REQ-014 Per-lane CondEx[k] from FlagsQ lane k: 000 EQ=Z; 001 NE=!Z; 010 GT=!Z&(N==V); 011 LT=N!=V; 100 GE=N==V; 101 LE=Z|(N!=V); 110 CS=C; 111 AL=1.
REQ-015 Scalar CondExS = AND of CondEx[] when CondE[3]=0, OR of CondEx[] when CondE[3]=1.
REQ-016 Kill = ShadowE | rst.
REQ-017 BranchTakenE = BranchE & CondExS & !Kill; PCSrcECU, RegWriteECU, MemWriteECU = the respective input & CondExS & !Kill.
REQ-018 LaneMaskECU[k] = CondEx[k] & RegWriteE & !Kill.
REQ-019 All outputs except FlagsQ and ShadowE are combinational with zero latency.
REQ-020 On a clock edge with !StallE & FlagWriteE & CondExS & !Kill, FlagsQ loads ALUFlagsE in the next cycle; flags are not updated for any lane when CondExS=0.
REQ-021 The shadow counter loads KILL_CYCLES on an edge with BranchTakenE=1 & !StallE.
REQ-022 The counter decrements by 1 on each edge with !StallE while it is nonzero.
REQ-023 ShadowE = (counter != 0).
REQ-024 A branch arriving while ShadowE=1 is squashed and does not reload the counter.
REQ-025 KILL_CYCLES=0: the shadow is never asserted.
REQ-026 StallE=1 holds FlagsQ and the counter unchanged; the combinational outputs are still evaluated.
REQ-027 A branch with FlagWriteE=1 that is taken updates both FlagsQ and the counter on the same edge.

Reset
REQ-028 While rst=1, every 1-bit enable output and LaneMaskECU are 0.
REQ-029 On an edge with rst=1, FlagsQ and the counter reset to 0 (ShadowE=0), overriding StallE, including mid-shadow.

Configuration
REQ-030 Macro COND_ANY_EN defined: ANY reduction is honoured per REQ-015.
REQ-031 Macro COND_ANY_EN undefined: CondE[3] is ignored and ALL reduction is always used; all other behaviour is identical.

Verification
REQ-032 Reset with LANES=4 -> FlagsQ=16'h0000, ShadowE=0; CondE=4'b0000 (EQ) with BranchE=1 -> BranchTakenE=0.
REQ-033 FlagWriteE=1, CondE=4'b0111, ALUFlagsE=16'h4444, one edge -> FlagsQ=16'h4444; then BranchE=1, CondE=4'b0000 -> BranchTakenE=1.
REQ-034 FlagsQ=16'h0004 (only lane 0 Z=1), CondE=4'b0000 -> CondExS=0, LaneMaskECU=4'b0001 with RegWriteE=1, RegWriteECU=0; with CondE=4'b1000 and COND_ANY_EN defined -> RegWriteECU=1.
REQ-035 Taken branch (CondE=4'b0111), KILL_CYCLES=2 -> ShadowE=1 for exactly 2 unstalled cycles, RegWriteECU=0 during them, and a second branch inside the shadow gives BranchTakenE=0; with StallE=1 for 3 cycles inside the shadow, the shadow is extended by 3.
REQ-036 FlagWriteE=1 with CondE=4'b0001 (NE) while FlagsQ=16'h4444 -> FlagsQ unchanged; rst asserted with counter=1 -> next cycle ShadowE=0 and FlagsQ=0.
